sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/mips_pkg.sv | 22 ++
 rtl/sram_controller.sv | 132 +++++++++++++
 tb/tb_sram_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory subsystem: SRAM controller state
// encoding, default address map and timing, and the word-index helper.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } sram_state_t;

    localparam int unsigned DATA_BASE_DEFAULT   = 1024;
    localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

    // Addresses below the base wrap modulo 2^17 words rather than faulting.
    function automatic logic [16:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return 17'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// 32-bit load/store front end for a 16-bit asynchronous SRAM: each access is
// split into a low and a high half-word cycle followed by a fixed settle wait.
module sram_controller
    import mips_pkg::*;
#(
    parameter int unsigned DATA_BASE   = DATA_BASE_DEFAULT,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam logic [7:0] CNT_LAST = 8'(WAIT_CYCLES - 1);

    sram_state_t r_state;
    sram_state_t w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [16:0] r_index;
    logic [31:0] r_wdata;
    logic        r_is_write;
    logic [31:0] r_read_data;

    logic        w_req;
    logic        w_latch;
    logic        w_dq_oe;
    logic [15:0] w_dq_out;
    logic        w_cap_lo;
    logic        w_cap_hi;

    assign w_req     = wr_en | rd_en;
    assign read_data = r_read_data;
    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        ready        = 1'b0;
        w_latch      = 1'b0;
        SRAM_ADDR    = 18'd0;
        SRAM_WE_N    = 1'b1;
        w_dq_oe      = 1'b0;
        w_dq_out     = r_wdata[15:0];
        w_cap_lo     = 1'b0;
        w_cap_hi     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = ~w_req;
                if (w_req) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_LO;
                end
            end
            ST_LO: begin
                SRAM_ADDR    = {r_index, 1'b0};
                SRAM_WE_N    = ~r_is_write;
                w_dq_oe      = r_is_write;
                w_cap_lo     = ~r_is_write;
                w_state_next = ST_HI;
            end
            ST_HI: begin
                SRAM_ADDR    = {r_index, 1'b1};
                SRAM_WE_N    = ~r_is_write;
                w_dq_oe      = r_is_write;
                w_dq_out     = r_wdata[31:16];
                w_cap_hi     = ~r_is_write;
                w_cnt_next   = 8'd0;
                w_state_next = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = 8'd0;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                ready        = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request fields are captured once so the pipeline may change them mid-access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index     <= 17'd0;
            r_wdata     <= 32'd0;
            r_is_write  <= 1'b0;
            r_read_data <= 32'd0;
        end else begin
            if (w_latch) begin
                r_index    <= word_index(address, 32'(DATA_BASE));
                r_wdata    <= write_data;
                r_is_write <= wr_en;
            end
            if (w_cap_lo) r_read_data[15:0]  <= SRAM_DQ;
            if (w_cap_hi) r_read_data[31:16] <= SRAM_DQ;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller against a behavioural 256K x 16
// asynchronous-read SRAM; directed vectors with hand-computed expectations.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n, sram_we_n;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_WE_N  (sram_we_n)
    );

    // Behavioural SRAM: async read onto the bus, write on the clock while WE_N low.
    logic [15:0] mem [0:262143];
    logic        sram_sel;
    assign sram_sel = ~sram_ce_n & (~sram_ub_n | ~sram_lb_n);
    assign sram_dq  = (sram_sel && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'bz;
    always @(posedge clk) begin
        if (sram_sel && !sram_we_n) mem[sram_addr] <= sram_dq;
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          completions = 0;
    int          mon_low = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    logic        s_ready [0:15];
    logic [17:0] s_addr  [0:15];
    logic        s_we    [0:15];
    logic [15:0] s_dq    [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input int hold, input int ncyc);
        @(posedge clk);
        #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            s_ready[i] = ready;
            s_addr[i]  = sram_addr;
            s_we[i]    = sram_we_n;
            s_dq[i]    = sram_dq;
            @(posedge clk);
            #1;
            if (i == hold - 1) begin
                // Scramble the request after acceptance; latched values must win.
                wr_en = 1'b0; rd_en = 1'b0;
                address = 32'hFFFF_FFF0; write_data = 32'h0;
            end
        end
    endtask

    function automatic logic [31:0] ready_pattern(input int ncyc);
        logic [31:0] p = 32'd0;
        for (int i = 0; i < ncyc; i++) p[i] = s_ready[i];
        return p;
    endfunction

    function automatic logic [31:0] we_pattern(input int ncyc);
        logic [31:0] p = 32'd0;
        for (int i = 0; i < ncyc; i++) p[i] = s_we[i];
        return p;
    endfunction

    // Monitor: a ready-high cycle that follows a ready-low run is a completion.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_low = 0;
            end else if (!ready) begin
                mon_low++;
            end else if (mon_low > 0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_completion: got completion expected none");
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("mon_read_data", read_data, mon_exp);
                    check("mon_ready_low_cycles", 32'(mon_low), 32'd5);
                end
                completions++;
                mon_low = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_read_data", read_data, 32'd0);
        check("reset_we_n", 32'(sram_we_n), 32'd1);
        check("reset_sram_addr", 32'(sram_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Write 0xDEADBEEF to base address.
        exp_q.push_back(32'h0000_0000);
        access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1, 6);
        check("wr_ready_pattern", ready_pattern(6), 32'h20);
        check("wr_lo_addr", 32'(s_addr[1]), 32'h0);
        check("wr_hi_addr", 32'(s_addr[2]), 32'h1);
        check("wr_we_pattern", we_pattern(6), 32'h39);
        check("wr_lo_dq", 32'(s_dq[1]), 32'hBEEF);
        check("wr_hi_dq", 32'(s_dq[2]), 32'hDEAD);
        check("wr_mem0", 32'(mem[0]), 32'hBEEF);
        check("wr_mem1", 32'(mem[1]), 32'hDEAD);

        // Read it back; WE_N must never drop.
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1, 6);
        check("rd_ready_pattern", ready_pattern(6), 32'h20);
        check("rd_we_pattern", we_pattern(6), 32'h3F);

        // Both enables high is a write; read_data keeps the last load value.
        exp_q.push_back(32'hDEAD_BEEF);
        access(1'b1, 1'b1, 32'd1028, 32'h1234_5678, 1, 6);
        check("both_mem2", 32'(mem[2]), 32'h5678);
        check("both_mem3", 32'(mem[3]), 32'h1234);

        // Reset pulsed during the HI cycle of a write.
        @(posedge clk);
        #1 wr_en = 1'b1; address = 32'd1036; write_data = 32'hAAAA_5555;
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_read_data", read_data, 32'd0);
        check("abort_sram_addr", 32'(sram_addr), 32'd0);
        check("abort_dq_released", 32'(sram_dq), 32'hBEEF);

        // Write request held for 12 cycles: two back-to-back accesses.
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        begin
            int c0;
            c0 = completions;
            access(1'b1, 1'b0, 32'd1032, 32'hCAFE_F00D, 12, 12);
            check("held_ready_pattern", ready_pattern(12), 32'h820);
            check("held_access_count", 32'(completions - c0), 32'd2);
        end
        check("held_mem4", 32'(mem[4]), 32'hF00D);
        check("held_mem5", 32'(mem[5]), 32'hCAFE);

        // Below-base address wraps to the top of the SRAM.
        exp_q.push_back(32'h0);
        access(1'b1, 1'b0, 32'd1020, 32'h2222_1111, 1, 6);
        check("wrap_mem_lo", 32'(mem[18'h3FFFE]), 32'h1111);
        check("wrap_mem_hi", 32'(mem[18'h3FFFF]), 32'h2222);
        exp_q.push_back(32'h2222_1111);
        access(1'b0, 1'b1, 32'd1020, 32'h0, 1, 6);
        check("wrap_rd_lo_addr", 32'(s_addr[1]), 32'h3FFFE);
        check("wrap_rd_hi_addr", 32'(s_addr[2]), 32'h3FFFF);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("total_completions", 32'(completions), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
